// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared constants and loader state type for the multi-port instruction memory
package imem_pkg;

  localparam logic [1:0] CTRL_READ = 2'd1;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_LOAD  = 4'd1;
  localparam logic [3:0] OP_STORE = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_AND   = 4'd5;
  localparam logic [3:0] OP_OR    = 4'd6;
  localparam logic [3:0] OP_XOR   = 4'd7;
  localparam logic [3:0] OP_SHL   = 4'd8;
  localparam logic [3:0] OP_SHR   = 4'd9;
  localparam logic [3:0] OP_JMP   = 4'd10;
  localparam logic [3:0] OP_JMPZ  = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

endpackage

// File: rtl/instr_mem_multiport_if.sv
// rtl/instr_mem_multiport_if.sv - core fetch ports and program-load handshake bundle
interface instr_mem_multiport_if #(
  parameter int NUM_PORTS = 16,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16
);

  logic [2*NUM_PORTS-1:0]      ctrl;
  logic [ADDR_W*NUM_PORTS-1:0] instr_addr;
  logic [DATA_W*NUM_PORTS-1:0] instr_out;
  logic [NUM_PORTS-1:0]        instr_valid;
  logic [NUM_PORTS-1:0]        addr_err;

  logic                        load_start;
  logic [ADDR_W-1:0]           load_base;
  logic [ADDR_W:0]             load_len;
  logic [DATA_W-1:0]           load_data;
  logic                        load_valid;
  logic                        load_ready;
  logic                        load_busy;
  logic                        load_done;
  logic                        load_err;

  modport master (
    output ctrl, instr_addr, load_start, load_base, load_len, load_data, load_valid,
    input  instr_out, instr_valid, addr_err, load_ready, load_busy, load_done, load_err
  );

  modport slave (
    input  ctrl, instr_addr, load_start, load_base, load_len, load_data, load_valid,
    output instr_out, instr_valid, addr_err, load_ready, load_busy, load_done, load_err
  );

endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - program-load FSM: range check, write pointer and word countdown
module imem_loader
  import imem_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 64,
  parameter int MEM_AW = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load_start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W:0]   load_len,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_valid,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_err,
  output logic              wr_en,
  output logic [MEM_AW-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy
);

  localparam logic [ADDR_W+1:0] DEPTH_END = (ADDR_W+2)'(DEPTH);

  load_state_t       state_q, state_d;
  logic [MEM_AW-1:0] ptr_q;
  logic [ADDR_W:0]   rem_q;
  logic              zero_done_q, err_q;
  logic              accept, len_zero, too_big;
  logic [ADDR_W+1:0] end_sum;

  // One extra bit over the nominal sum so a huge base+len cannot wrap past the check.
  assign end_sum  = {2'b00, load_base} + {1'b0, load_len};
  assign len_zero = (load_len == '0);
  assign too_big  = end_sum > DEPTH_END;
  assign accept   = (state_q == IDLE) && load_start;

  always_comb begin
    state_d    = state_q;
    load_ready = 1'b0;
    wr_en      = 1'b0;
    case (state_q)
      IDLE: if (accept && !len_zero && !too_big) state_d = LOAD;
      LOAD: begin
        load_ready = 1'b1;
        wr_en      = load_valid;
        if (load_valid && rem_q == (ADDR_W+1)'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wr_addr   = ptr_q;
  assign wr_data   = load_data;
  assign busy      = (state_q != IDLE);
  assign load_done = (state_q == DONE) || zero_done_q;
  assign load_err  = err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      zero_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      zero_done_q <= accept && len_zero;
      err_q       <= accept && !len_zero && too_big;
      if (accept) begin
        ptr_q <= load_base[MEM_AW-1:0];
        rem_q <= load_len;
      end else if (wr_en) begin
        ptr_q <= ptr_q + MEM_AW'(1);
        rem_q <= rem_q - (ADDR_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/instr_mem_multiport.sv
// rtl/instr_mem_multiport.sv - N-port registered-read instruction memory with run-time loader; IMEM_PARITY_EN adds per-word parity
module instr_mem_multiport
  import imem_pkg::*;
#(
  parameter int NUM_PORTS = 16,
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 16,
  parameter int DEPTH     = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  instr_mem_multiport_if.slave bus
);

  localparam int MEM_AW = $clog2(DEPTH);
`ifdef IMEM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W+1)'(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic              wr_en;
  logic [MEM_AW-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [WORD_W-1:0] wr_word;
  logic              busy;

  imem_loader #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH),
    .MEM_AW(MEM_AW)
  ) u_loader (
    .clock     (clock),
    .reset     (reset),
    .load_start(bus.load_start),
    .load_base (bus.load_base),
    .load_len  (bus.load_len),
    .load_data (bus.load_data),
    .load_valid(bus.load_valid),
    .load_ready(bus.load_ready),
    .load_done (bus.load_done),
    .load_err  (bus.load_err),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  assign bus.load_busy = busy;

`ifdef IMEM_PARITY_EN
  assign wr_word = {^wr_data, wr_data};
`else
  assign wr_word = wr_data;
`endif

  // Storage is deliberately not reset: a reset must not wipe the loaded program.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_word;
  end

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic [WORD_W-1:0] word;
    logic              rd, in_range, word_bad;
    logic [DATA_W-1:0] out_q;
    logic              valid_q, err_q;

    assign addr     = bus.instr_addr[k*ADDR_W +: ADDR_W];
    assign rd       = (bus.ctrl[2*k +: 2] == CTRL_READ) && !busy;
    assign in_range = {1'b0, addr} < DEPTH_LIM;
    assign word     = mem[addr[MEM_AW-1:0]];
`ifdef IMEM_PARITY_EN
    assign word_bad = ^word;
`else
    assign word_bad = 1'b0;
`endif

    always_ff @(posedge clock) begin
      if (reset) begin
        out_q   <= '0;
        valid_q <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        valid_q <= rd;
        err_q   <= rd && (!in_range || word_bad);
        if (rd) out_q <= (in_range && !word_bad) ? word[DATA_W-1:0] : '0;
      end
    end

    assign bus.instr_out[k*DATA_W +: DATA_W] = out_q;
    assign bus.instr_valid[k]                = valid_q;
    assign bus.addr_err[k]                   = err_q;
  end

endmodule
